seq_tff_toggle_rx: RTL and testbench



---
 rtl/seq_tff_pkg.sv | 13 +
 rtl/seq_tff_toggle_det.sv | 28 ++
 rtl/seq_tff_toggle_rx.sv | 94 +++++++++
 tb/tb_seq_tff_toggle_rx.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/seq_tff_pkg.sv
// Shared types and constants for the toggle-line (TFF) driver/receiver pair.
package seq_tff_pkg;

    localparam int unsigned NBITS_DEFAULT = 8;

    // Width of a counter that indexes bit positions 0..n-1 (never below 1).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [NBITS_DEFAULT-1:0] word_t;

endpackage

// File: rtl/seq_tff_toggle_det.sv
// Toggle detector: recovers the driver's t bit as q XOR the previous sampled q.
module seq_tff_toggle_det (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic q,
    input  logic clear,
    output logic dbit_c,
    output logic dbit_v_c
);

    logic prev_q;

    // Reset level matches the driver's q=0; clear resyncs to the live level.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q <= 1'b0;
        end else if (clear || en) begin
            prev_q <= q;
        end
    end

    always_comb begin
        dbit_c   = q ^ prev_q;
        dbit_v_c = en & ~clear;
    end

endmodule

// File: rtl/seq_tff_toggle_rx.sv
// Toggle-line receiver: decodes bits, deserializes LSB-first, single-entry val/rdy buffer.
module seq_tff_toggle_rx
    import seq_tff_pkg::*;
#(
    parameter int unsigned NBITS = NBITS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          q,
    input  logic                          clear,
    output logic [NBITS-1:0]              out_msg,
    output logic                          out_val,
    input  logic                          out_rdy,
    output logic                          overflow,
    output logic [cnt_width(NBITS)-1:0]   bit_cnt
);

    localparam int unsigned CW = cnt_width(NBITS);
    localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

    logic             dbit_c;
    logic             dbit_v_c;
    logic [NBITS-1:0] shreg;
    logic [NBITS-1:0] shreg_n;
    logic [NBITS-1:0] word_c;
    logic [CW-1:0]    cnt_n;
    logic [NBITS-1:0] msg_n;
    logic             val_n;
    logic             ovf_n;
    logic             free_c;

    seq_tff_toggle_det u_det (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .q        (q),
        .clear    (clear),
        .dbit_c   (dbit_c),
        .dbit_v_c (dbit_v_c)
    );

    // Deserializer and output buffer next-state.
    always_comb begin
        cnt_n   = bit_cnt;
        shreg_n = shreg;
        msg_n   = out_msg;
        val_n   = out_val;
        ovf_n   = overflow;
        free_c  = ~out_val | out_rdy;
        word_c  = shreg | (NBITS'(dbit_c) << bit_cnt);

        if (out_val && out_rdy) begin
            val_n = 1'b0;
        end

        if (clear) begin
            cnt_n   = '0;
            shreg_n = '0;
            ovf_n   = 1'b0;
        end else if (dbit_v_c) begin
            if (bit_cnt == LAST) begin
                cnt_n   = '0;
                shreg_n = '0;
                if (free_c) begin
                    msg_n = word_c;
                    val_n = 1'b1;
                end else begin
                    ovf_n = 1'b1;
                end
            end else begin
                cnt_n   = bit_cnt + CW'(1);
                shreg_n = word_c;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            shreg    <= '0;
            out_msg  <= '0;
            out_val  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            bit_cnt  <= cnt_n;
            shreg    <= shreg_n;
            out_msg  <= msg_n;
            out_val  <= val_n;
            overflow <= ovf_n;
        end
    end

endmodule

// File: tb/tb_seq_tff_toggle_rx.sv
// Directed bench for seq_tff_toggle_rx (NBITS=8): vector table plus corner-case sequences.
module tb_seq_tff_toggle_rx;
    import seq_tff_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic       q;
    logic       clear;
    logic       out_rdy;
    word_t      out_msg;
    logic       out_val;
    logic       overflow;
    logic [2:0] bit_cnt;

    int   checks = 0;
    int   errors = 0;
    logic line   = 1'b0;

    typedef struct {
        logic  en;
        logic  q;
        logic  clr;
        logic  rdy;
        word_t msg;
        logic  val;
        logic  ovf;
        logic [2:0] cnt;
    } vec_t;

    vec_t tbl[$];

    seq_tff_toggle_rx #(.NBITS(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .q        (q),
        .clear    (clear),
        .out_msg  (out_msg),
        .out_val  (out_val),
        .out_rdy  (out_rdy),
        .overflow (overflow),
        .bit_cnt  (bit_cnt)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic e, input logic qq, input logic c, input logic r,
                                input word_t m, input logic v, input logic o, input logic [2:0] n);
        vec_t x;
        x.en = e; x.q = qq; x.clr = c; x.rdy = r;
        x.msg = m; x.val = v; x.ovf = o; x.cnt = n;
        tbl.push_back(x);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step(input logic e, input logic qq, input logic c, input logic r);
        en = e; q = qq; clear = c; out_rdy = r;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            step(tbl[i].en, tbl[i].q, tbl[i].clr, tbl[i].rdy);
            chk($sformatf("vec%0d msg", i), 32'(out_msg),  32'(tbl[i].msg));
            chk($sformatf("vec%0d val", i), 32'(out_val),  32'(tbl[i].val));
            chk($sformatf("vec%0d ovf", i), 32'(overflow), 32'(tbl[i].ovf));
            chk($sformatf("vec%0d cnt", i), 32'(bit_cnt),  32'(tbl[i].cnt));
        end
    endtask

    // Drives a word as a toggle waveform; optional even-toggle idle gaps before each sample.
    task automatic send_word(input word_t w, input logic rdy_rest, input logic rdy_last,
                             input bit gaps, input bit hold_val);
        for (int i = 0; i < 8; i++) begin
            if (gaps) begin
                step(1'b0, ~line, 1'b0, 1'b0);
                step(1'b0, line, 1'b0, 1'b0);
                chk($sformatf("gap cnt b%0d", i), 32'(bit_cnt), 32'(i));
            end
            line = line ^ w[i];
            step(1'b1, line, 1'b0, (i == 7) ? rdy_last : rdy_rest);
            if (hold_val) chk($sformatf("hold val b%0d", i), 32'(out_val), 32'd1);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; q = 1'b0; clear = 1'b0; out_rdy = 1'b0;

        // Test 1: q 1,1,0,0,0,1,1,0 -> 0xA5
        add(1,1,0,1, 8'h00,0,0,3'd1); add(1,1,0,1, 8'h00,0,0,3'd2);
        add(1,0,0,1, 8'h00,0,0,3'd3); add(1,0,0,1, 8'h00,0,0,3'd4);
        add(1,0,0,1, 8'h00,0,0,3'd5); add(1,1,0,1, 8'h00,0,0,3'd6);
        add(1,1,0,1, 8'h00,0,0,3'd7); add(1,0,0,1, 8'hA5,1,0,3'd0);
        // Test 2: q held 0 -> 0x00 (first cycle drains 0xA5)
        add(1,0,0,1, 8'hA5,0,0,3'd1); add(1,0,0,1, 8'hA5,0,0,3'd2);
        add(1,0,0,1, 8'hA5,0,0,3'd3); add(1,0,0,1, 8'hA5,0,0,3'd4);
        add(1,0,0,1, 8'hA5,0,0,3'd5); add(1,0,0,1, 8'hA5,0,0,3'd6);
        add(1,0,0,1, 8'hA5,0,0,3'd7); add(1,0,0,1, 8'h00,1,0,3'd0);
        // Test 2 cont.: q alternating -> 0xFF
        add(1,1,0,1, 8'h00,0,0,3'd1); add(1,0,0,1, 8'h00,0,0,3'd2);
        add(1,1,0,1, 8'h00,0,0,3'd3); add(1,0,0,1, 8'h00,0,0,3'd4);
        add(1,1,0,1, 8'h00,0,0,3'd5); add(1,0,0,1, 8'h00,0,0,3'd6);
        add(1,1,0,1, 8'h00,0,0,3'd7); add(1,0,0,1, 8'hFF,1,0,3'd0);

        repeat (2) @(posedge clk);
        #1;
        chk("reset msg", 32'(out_msg), 32'h0);
        chk("reset val", 32'(out_val), 32'd0);
        chk("reset ovf", 32'(overflow), 32'd0);
        chk("reset cnt", 32'(bit_cnt), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        run_table(0, 23);
        line = 1'b0;

        // Test 3: backpressure and sticky overflow
        step(1'b0, line, 1'b0, 1'b1);
        chk("t3 drain val", 32'(out_val), 32'd0);
        chk("t3 drain msg", 32'(out_msg), 32'hFF);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3 w1 msg", 32'(out_msg), 32'h3C);
        chk("t3 w1 val", 32'(out_val), 32'd1);
        chk("t3 w1 ovf", 32'(overflow), 32'd0);
        send_word(8'h81, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3 w2 msg", 32'(out_msg), 32'h3C);
        chk("t3 w2 val", 32'(out_val), 32'd1);
        chk("t3 w2 ovf", 32'(overflow), 32'd1);
        step(1'b0, line, 1'b0, 1'b1);
        chk("t3 rdy val", 32'(out_val), 32'd0);
        chk("t3 rdy ovf", 32'(overflow), 32'd1);
        chk("t3 rdy msg", 32'(out_msg), 32'h3C);
        step(1'b0, line, 1'b0, 1'b0);
        chk("t3 sticky ovf", 32'(overflow), 32'd1);
        step(1'b0, line, 1'b1, 1'b0);
        chk("t3 clear ovf", 32'(overflow), 32'd0);
        chk("t3 clear cnt", 32'(bit_cnt), 32'd0);

        // Test 4: drain and completion in the same cycle
        send_word(8'h11, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4 w1 msg", 32'(out_msg), 32'h11);
        chk("t4 w1 val", 32'(out_val), 32'd1);
        send_word(8'h22, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t4 w2 msg", 32'(out_msg), 32'h22);
        chk("t4 w2 ovf", 32'(overflow), 32'd0);
        step(1'b0, line, 1'b0, 1'b1);
        chk("t4 drain val", 32'(out_val), 32'd0);

        // Test 5a: clear mid-word resyncs prev_q to the live level
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);
        chk("t5 partial cnt", 32'(bit_cnt), 32'd3);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        chk("t5 clear cnt", 32'(bit_cnt), 32'd0);
        chk("t5 clear val", 32'(out_val), 32'd0);
        line = 1'b1;
        send_word(8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5 resync msg", 32'(out_msg), 32'h5A);
        chk("t5 resync val", 32'(out_val), 32'd1);
        step(1'b0, line, 1'b0, 1'b1);
        // Test 5b: even toggles during en=0 gaps decode nothing
        send_word(8'hC3, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t5 gap msg", 32'(out_msg), 32'hC3);
        chk("t5 gap val", 32'(out_val), 32'd1);

        // Test 6: asynchronous reset mid-clock with a buffered word and partial word
        step(1'b0, line, 1'b0, 1'b1);
        send_word(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, line, 1'b0, 1'b0);
        chk("t6 pre val", 32'(out_val), 32'd1);
        chk("t6 pre cnt", 32'(bit_cnt), 32'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("t6 async val", 32'(out_val), 32'd0);
        chk("t6 async msg", 32'(out_msg), 32'h0);
        chk("t6 async cnt", 32'(bit_cnt), 32'd0);
        @(negedge clk);
        q = 1'b0; line = 1'b0; en = 1'b0;
        reset = 1'b1;
        run_table(0, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
